pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
// PURPOSE
//   Programmable square/PWM pulse-train transmitter: drives sig_out with a configured period and high time,
//   for a configured number of periods or continuously. It is the stimulus source feeding signal_in of the
//   frequency/period/pulse-width counter, enabling on-chip self-test of the measurement path.
//   New configurations take effect only at a period boundary, so no glitched or partial period is emitted.
// PARAMETERS
//   CNT_W     32   width of period/high-time counters, in clk cycles
//   BURST_W   16   width of the burst (period count) field; 0 = continuous
// PORTS
//   clk          in   1        system clock (50 MHz nominal)
//   rst          in   1        asynchronous, active-low reset
//   cfg_valid    in   1        configuration offered this cycle
//   cfg_ready    out  1        configuration accepted when cfg_valid & cfg_ready
//   cfg_period   in   CNT_W    period in clk cycles; legal range >= 2
//   cfg_high     in   CNT_W    high time in clk cycles; 0 = constant low, >= period = constant high
//   cfg_burst    in   BURST_W  number of periods to emit; 0 = run until stop
//   start        in   1        one-cycle pulse: begin emission using the shadow configuration
//   stop         in   1        one-cycle pulse: finish the current period, then go idle
//   sig_out      out  1        generated waveform (registered)
//   busy         out  1        high from start until the last period completes
//   period_tick  out  1        one-cycle pulse on the last cycle of each emitted period
//   done         out  1        one-cycle pulse when a burst or stop completes
//   cfg_err      out  1        one-cycle pulse: offered config rejected (cfg_period < 2)
// BEHAVIOUR
//   Reset (rst=0, async): sig_out=0, busy=0, period_tick=0, done=0, cfg_err=0, cfg_ready=1, FSM=IDLE,
//     shadow period=2, high=1, burst=0. Deassertion is synchronised externally.
//   Config handshake: cfg_ready=1 always except on the boundary cycle (period_tick) of a running train.
//     Accepted config is written to a pending register; cfg_period<2 -> pending is not written, cfg_err
//     pulses the next cycle. Pending copies into shadow in IDLE immediately, in RUN at the next boundary.
//     A second accept before the boundary overwrites pending (last one wins).
//   FSM: IDLE -> HIGH on start (1 cycle latency: sig_out rises the cycle after start).
//     HIGH: sig_out=1 for high cycles -> LOW; LOW: sig_out=0 for (period-high) cycles -> boundary.
//     At boundary: period_tick=1; burst count incremented; if burst!=0 and count==burst, or stop latched,
//     -> IDLE with done=1, busy=0; else -> HIGH (or LOW if high=0) with the new shadow applied.
//   Degenerate duty: high=0 -> stay in LOW whole period; high>=period -> stay HIGH whole period;
//     period_tick/burst counting still occur every period.
//   start while busy: ignored. stop while IDLE: ignored. start and stop in same cycle in IDLE: stop wins
//     (no emission, no done). stop latched is cleared on entering IDLE.
//   Counters: single CNT_W down-counter reloaded at each phase change; no wrap, all compares unsigned.
//   Burst counter BURST_W bits; in continuous mode it saturates at all-ones (no wrap).
//   Reset mid-period: sig_out drops to 0 asynchronously, no done pulse.
// STRUCTURE
//   Package fcnt_pkg: CNT_W/BURST_W defaults, FSM state encoding (IDLE, HIGH, LOW), MIN_PERIOD=2,
//     CLOCK_FREQ=50_000_000 shared with the counter and display blocks.
//   One sub-module: pulse_cfg_shadow (pending + shadow registers, validation, cfg_err, boundary load);
//     FSM and counters stay in pulse_train_gen.
// TESTING
//   1. cfg period=50_000_000, high=25_000_000, burst=2, start -> 2 periods, sig_out high 25e6 cycles each,
//      2 period_tick, done 1 cycle after 2nd tick, busy low; counter reads 1 Hz / 50 %.
//   2. period=10, high=7, burst=0, start, stop after 35 cycles -> period 4 completes fully (40 cycles), done,
//      sig_out 0, no truncated high phase.
//   3. Running period=10/high=5; accept period=4/high=1 mid-period -> current period unchanged, next period
//      4 cycles with 1 high; two accepts before boundary -> only the last applied.
//   4. cfg period=1 -> cfg_err one pulse, shadow unchanged; period=6/high=0 -> sig_out stays 0, 6-cycle ticks;
//      high=9 -> sig_out constant 1, ticks every 6 cycles.
//   5. Assert rst low mid-HIGH -> sig_out=0, busy=0 immediately; after release IDLE, cfg_ready=1, no done.
//   6. start+stop same cycle in IDLE -> no emission; start while busy -> ignored, burst count unaffected.

Source files
------------

// File: rtl/fcnt_pkg.sv
// Shared definitions for the frequency-counter self-test path: default widths,
// pulse generator state encoding and the nominal system clock rate.
package fcnt_pkg;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_BURST_W = 16;
  localparam int MIN_PERIOD  = 2;
  localparam int CLOCK_FREQ  = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pulse_state_t;
endpackage

// File: rtl/pulse_cfg_shadow.sv
// Pending/shadow configuration store for the pulse train generator: validates
// offered configs, flags rejects and hands the pending set over on request.
module pulse_cfg_shadow
  import fcnt_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  input  logic               i_cfg_ready,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [CNT_W-1:0]   i_cfg_high,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic               i_load,
  output logic [CNT_W-1:0]   o_period,
  output logic [CNT_W-1:0]   o_high,
  output logic [BURST_W-1:0] o_burst,
  output logic [CNT_W-1:0]   o_nxt_period,
  output logic [CNT_W-1:0]   o_nxt_high,
  output logic               o_cfg_err
);

  logic [CNT_W-1:0]   r_pend_period, r_pend_high, r_shd_period, r_shd_high;
  logic [BURST_W-1:0] r_pend_burst, r_shd_burst;
  logic               r_pend_vld, r_err;
  logic               w_accept, w_bad;

  assign w_accept = i_cfg_valid & i_cfg_ready;
  assign w_bad    = (i_cfg_period < CNT_W'(MIN_PERIOD));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_period <= CNT_W'(MIN_PERIOD);
      r_pend_high   <= CNT_W'(1);
      r_pend_burst  <= '0;
      r_pend_vld    <= 1'b0;
      r_shd_period  <= CNT_W'(MIN_PERIOD);
      r_shd_high    <= CNT_W'(1);
      r_shd_burst   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_accept & w_bad;
      // A fresh accept keeps pending marked even if a load drains it this cycle.
      if (w_accept && !w_bad) begin
        r_pend_period <= i_cfg_period;
        r_pend_high   <= i_cfg_high;
        r_pend_burst  <= i_cfg_burst;
        r_pend_vld    <= 1'b1;
      end else if (i_load) begin
        r_pend_vld <= 1'b0;
      end
      if (i_load && r_pend_vld) begin
        r_shd_period <= r_pend_period;
        r_shd_high   <= r_pend_high;
        r_shd_burst  <= r_pend_burst;
      end
    end
  end

  assign o_period     = r_shd_period;
  assign o_high       = r_shd_high;
  assign o_burst      = r_shd_burst;
  assign o_nxt_period = r_pend_vld ? r_pend_period : r_shd_period;
  assign o_nxt_high   = r_pend_vld ? r_pend_high : r_shd_high;
  assign o_cfg_err    = r_err;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable square/PWM pulse-train source; configuration changes only take
// effect on period boundaries so every emitted period is complete.
module pulse_train_gen
  import fcnt_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [CNT_W-1:0]   i_cfg_high,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_sig_out,
  output logic               o_busy,
  output logic               o_period_tick,
  output logic               o_done,
  output logic               o_cfg_err
);

  pulse_state_t       r_state, w_nxt_state, w_start_state;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt, w_start_cnt;
  logic [CNT_W-1:0]   w_period, w_high, w_nperiod, w_nhigh;
  logic [BURST_W-1:0] r_bcnt, w_nxt_bcnt, w_burst, w_bcnt_inc;
  logic               r_stop, w_nxt_stop, r_sig, r_done;
  logic               w_tick, w_busy, w_ready, w_load, w_end, w_const_high;

  pulse_cfg_shadow #(.CNT_W(CNT_W), .BURST_W(BURST_W)) u_shadow (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_ready (w_ready),
    .i_cfg_period(i_cfg_period),
    .i_cfg_high  (i_cfg_high),
    .i_cfg_burst (i_cfg_burst),
    .i_load      (w_load),
    .o_period    (w_period),
    .o_high      (w_high),
    .o_burst     (w_burst),
    .o_nxt_period(w_nperiod),
    .o_nxt_high  (w_nhigh),
    .o_cfg_err   (o_cfg_err)
  );

  assign w_const_high  = (w_high >= w_period);
  assign w_start_state = (w_nhigh == '0) ? ST_LOW : ST_HIGH;
  // Degenerate duties run the whole period in a single phase.
  assign w_start_cnt   = ((w_nhigh == '0) || (w_nhigh >= w_nperiod)) ?
                         (w_nperiod - CNT_W'(1)) : (w_nhigh - CNT_W'(1));
  assign w_bcnt_inc    = (&r_bcnt) ? r_bcnt : (r_bcnt + BURST_W'(1));
  assign w_end         = ((w_burst != '0) && (w_bcnt_inc == w_burst)) || r_stop || i_stop;
  assign w_load        = (r_state == ST_IDLE) || w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_stop  <= 1'b0;
      r_sig   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_bcnt  <= w_nxt_bcnt;
      r_stop  <= w_nxt_stop;
      r_sig   <= (w_nxt_state == ST_HIGH);
      r_done  <= w_tick & w_end;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_bcnt  = r_bcnt;
    w_nxt_stop  = r_stop | i_stop;
    case (r_state)
      ST_IDLE: begin
        w_nxt_stop = 1'b0;
        if (i_start && !i_stop) begin
          w_nxt_state = w_start_state;
          w_nxt_cnt   = w_start_cnt;
          w_nxt_bcnt  = '0;
        end
      end
      ST_HIGH, ST_LOW: begin
        if (w_tick) begin
          w_nxt_bcnt = w_bcnt_inc;
          if (w_end) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_stop  = 1'b0;
          end else begin
            w_nxt_state = w_start_state;
            w_nxt_cnt   = w_start_cnt;
          end
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_LOW;
          w_nxt_cnt   = w_period - w_high - CNT_W'(1);
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_busy  = (r_state != ST_IDLE);
    w_tick  = (r_cnt == '0) &&
              ((r_state == ST_LOW) || ((r_state == ST_HIGH) && w_const_high));
    w_ready = !w_tick;
  end

  assign o_cfg_ready   = w_ready;
  assign o_sig_out     = r_sig;
  assign o_busy        = w_busy;
  assign o_period_tick = w_tick;
  assign o_done        = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomised scoreboard bench for pulse_train_gen: stimulus pushes the expected
// periods and completions, a monitor measures the waveform and pops them.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cfgValid, cfgReady;
  logic [31:0] cfgPeriod, cfgHigh;
  logic [15:0] cfgBurst;
  logic        start, stop;
  logic        sigOut, busy, periodTick, done, cfgErr;

  typedef struct {
    int period;
    int high;
  } period_t;

  period_t expPer[$];
  int      expDone[$];
  int      expErr[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0, hi = 0, perCount = 0, cycleNo = 0, lastTick = 0, doneCount = 0;

  pulse_train_gen #(.CNT_W(32), .BURST_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_cfg_valid  (cfgValid),
    .o_cfg_ready  (cfgReady),
    .i_cfg_period (cfgPeriod),
    .i_cfg_high   (cfgHigh),
    .i_cfg_burst  (cfgBurst),
    .i_start      (start),
    .i_stop       (stop),
    .o_sig_out    (sigOut),
    .o_busy       (busy),
    .o_period_tick(periodTick),
    .o_done       (done),
    .o_cfg_err    (cfgErr)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic checkPresent(input string name, input int qsize);
    checks++;
    if (qsize == 0) begin
      errors++;
      $display("[TB] FAIL %s actual=unexpected_pulse required=no_pulse", name);
    end
  endtask

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: a run emits n whole periods of the given shape, then one done.
  task automatic expectRun(input int p, input int h, input int n);
    period_t e;
    e.period = p;
    e.high   = minI(h, p);
    for (int i = 0; i < n; i++) expPer.push_back(e);
    expDone.push_back(n);
  endtask

  // Monitor: measures each period up to its tick and checks completions.
  always @(negedge clk) begin
    if (!rstN) begin
      cyc = 0;
      hi = 0;
      perCount = 0;
    end else begin
      cycleNo++;
      if (busy) begin
        cyc++;
        if (sigOut) hi++;
      end
      if (periodTick) begin
        checkOutput("cfg_ready_on_tick", int'(cfgReady), 0);
        checkPresent("period_tick", expPer.size());
        if (expPer.size() != 0) begin
          period_t e;
          e = expPer.pop_front();
          checkOutput("period_length", cyc, e.period);
          checkOutput("high_time", hi, e.high);
        end
        cyc = 0;
        hi = 0;
        perCount++;
        lastTick = cycleNo;
      end
      if (done) begin
        checkPresent("done", expDone.size());
        if (expDone.size() != 0) checkOutput("periods_per_run", perCount, expDone.pop_front());
        checkOutput("done_after_last_tick", cycleNo - lastTick, 1);
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput("sig_out_at_done", int'(sigOut), 0);
        perCount = 0;
        doneCount++;
      end
      if (cfgErr) begin
        checkPresent("cfg_err", expErr.size());
        if (expErr.size() != 0) void'(expErr.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input int h, input int b);
    int waited = 0;
    cfgValid  = 1'b1;
    cfgPeriod = p;
    cfgHigh   = h;
    cfgBurst  = 16'(b);
    while (!cfgReady && waited < 50) begin
      cycles(1);
      waited++;
    end
    if (!cfgReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL cfg_handshake actual=not_ready required=ready");
    end
    if (p < 2) expErr.push_back(1);
    cycles(1);
    cfgValid = 1'b0;
  endtask

  task automatic startRun();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic stopAt(input int s);
    cycles(s - 1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
  endtask

  task automatic waitDone(input int d0, input int budget);
    int n = 0;
    while (doneCount == d0 && n < budget) begin
      cycles(1);
      n++;
    end
    if (doneCount == d0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout actual=no_done required=done_within_%0d", budget);
    end
  endtask

  initial begin
    int p, h, b, s, k, n, d0, pA, hA, pB, hB;
    rstN = 1'b0;
    cfgValid = 1'b0;
    cfgPeriod = '0;
    cfgHigh = '0;
    cfgBurst = '0;
    start = 1'b0;
    stop = 1'b0;
    cycles(3);
    checkOutput("reset_sig_out", int'(sigOut), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_tick", int'(periodTick), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_cfg_err", int'(cfgErr), 0);
    checkOutput("reset_cfg_ready", int'(cfgReady), 1);
    rstN = 1'b1;
    cycles(2);

    // Default shadow after reset: period 2, high 1, continuous.
    expectRun(2, 1, 1);
    d0 = doneCount;
    startRun();
    stopAt(1);
    waitDone(d0, 20);

    // Random bursts, with rejected configs and ignored starts mixed in.
    for (int it = 0; it < 8; it++) begin
      if (it == 0) begin
        p = 20; h = 10; b = 2;
      end else begin
        p = $urandom_range(2, 16);
        h = $urandom_range(0, p + 4);
        b = $urandom_range(1, 4);
      end
      applyStimulus(p, h, b);
      if (it % 3 == 1) applyStimulus($urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(1, 4));
      expectRun(p, h, b);
      d0 = doneCount;
      startRun();
      if (it % 2 == 1) begin
        cycles($urandom_range(0, p - 2));
        startRun();
      end
      waitDone(d0, b * p + 20);
    end

    // Continuous runs ended by stop: the period holding the stop always completes.
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        p = 10; h = 7; s = 35;
      end else begin
        p = $urandom_range(2, 12);
        h = $urandom_range(0, p + 3);
        s = $urandom_range(1, 4 * p);
      end
      n = (s + p - 1) / p;
      applyStimulus(p, h, 0);
      expectRun(p, h, n);
      d0 = doneCount;
      startRun();
      stopAt(s);
      waitDone(d0, p + 20);
    end

    // Mid-period reconfiguration: only the last accepted config applies next period.
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        p = 10; h = 5; pA = 7; hA = 3; pB = 4; hB = 1;
      end else begin
        p = $urandom_range(3, 12);
        h = $urandom_range(0, p + 3);
        pA = $urandom_range(2, 12);
        hA = $urandom_range(0, pA + 3);
        pB = $urandom_range(2, 12);
        hB = $urandom_range(0, pB + 3);
      end
      applyStimulus(p, h, 3);
      expPer.push_back('{p, minI(h, p)});
      expPer.push_back('{pB, minI(hB, pB)});
      expPer.push_back('{pB, minI(hB, pB)});
      expDone.push_back(3);
      d0 = doneCount;
      startRun();
      k = $urandom_range(1, p - 2);
      cycles(k - 1);
      cfgValid = 1'b1; cfgPeriod = pA; cfgHigh = hA; cfgBurst = 16'd3;
      cycles(1);
      cfgPeriod = pB; cfgHigh = hB;
      cycles(1);
      cfgValid = 1'b0;
      waitDone(d0, p + 2 * pB + 20);
    end

    // start and stop together in IDLE: stop wins, nothing is emitted.
    applyStimulus(5, 2, 1);
    start = 1'b1;
    stop = 1'b1;
    cycles(1);
    start = 1'b0;
    stop = 1'b0;
    cycles(10);
    checkOutput("start_stop_busy", int'(busy), 0);
    checkOutput("start_stop_sig_out", int'(sigOut), 0);

    // Asynchronous reset in the middle of a high phase.
    applyStimulus(20, 15, 0);
    startRun();
    cycles(3);
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_sig_out", int'(sigOut), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    expPer.delete();
    expDone.delete();
    cycles(2);
    rstN = 1'b1;
    #1;
    checkOutput("post_reset_cfg_ready", int'(cfgReady), 1);
    checkOutput("post_reset_done", int'(done), 0);
    cycles(5);
    expectRun(2, 1, 2);
    d0 = doneCount;
    startRun();
    stopAt(3);
    waitDone(d0, 20);

    cycles(5);
    checkOutput("leftover_periods", expPer.size(), 0);
    checkOutput("leftover_dones", expDone.size(), 0);
    checkOutput("leftover_cfg_errs", expErr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
